// File: rtl/ebpc_pkg.sv
// Shared EBPC types and constants: block-length field width and the
// decoder-arbiter state encoding.
package ebpc_pkg;

    localparam int LOG_MAX_WORDS = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        RUN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ebpc_decoder_arbiter_if.sv
// Requester-side and decoder-side stream bundle of the EBPC decoder arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface ebpc_decoder_arbiter_if #(
    parameter int N_REQ         = 2,
    parameter int DATA_W        = 8,
    parameter int LOG_MAX_WORDS = ebpc_pkg::LOG_MAX_WORDS
);

    logic [N_REQ-1:0][LOG_MAX_WORDS-1:0] req_num_words_i;
    logic [N_REQ-1:0]                    req_num_words_vld_i;
    logic [N_REQ-1:0]                    req_num_words_rdy_o;
    logic [N_REQ-1:0][DATA_W-1:0]        req_bpc_i;
    logic [N_REQ-1:0]                    req_bpc_vld_i;
    logic [N_REQ-1:0]                    req_bpc_rdy_o;
    logic [N_REQ-1:0][DATA_W-1:0]        req_znz_i;
    logic [N_REQ-1:0]                    req_znz_vld_i;
    logic [N_REQ-1:0]                    req_znz_rdy_o;
    logic [N_REQ-1:0][DATA_W-1:0]        req_data_o;
    logic [N_REQ-1:0]                    req_data_vld_o;
    logic [N_REQ-1:0]                    req_data_last_o;
    logic [N_REQ-1:0]                    req_data_rdy_i;

    logic [LOG_MAX_WORDS-1:0]            dec_num_words_o;
    logic                                dec_num_words_vld_o;
    logic                                dec_num_words_rdy_i;
    logic [DATA_W-1:0]                   dec_bpc_o;
    logic                                dec_bpc_vld_o;
    logic                                dec_bpc_rdy_i;
    logic [DATA_W-1:0]                   dec_znz_o;
    logic                                dec_znz_vld_o;
    logic                                dec_znz_rdy_i;
    logic [DATA_W-1:0]                   dec_data_i;
    logic                                dec_data_vld_i;
    logic                                dec_data_rdy_o;

    modport slave (
        input  req_num_words_i, req_num_words_vld_i,
        output req_num_words_rdy_o,
        input  req_bpc_i, req_bpc_vld_i,
        output req_bpc_rdy_o,
        input  req_znz_i, req_znz_vld_i,
        output req_znz_rdy_o,
        output req_data_o, req_data_vld_o, req_data_last_o,
        input  req_data_rdy_i,
        output dec_num_words_o, dec_num_words_vld_o,
        input  dec_num_words_rdy_i,
        output dec_bpc_o, dec_bpc_vld_o,
        input  dec_bpc_rdy_i,
        output dec_znz_o, dec_znz_vld_o,
        input  dec_znz_rdy_i,
        input  dec_data_i, dec_data_vld_i,
        output dec_data_rdy_o
    );

    modport master (
        output req_num_words_i, req_num_words_vld_i,
        input  req_num_words_rdy_o,
        output req_bpc_i, req_bpc_vld_i,
        input  req_bpc_rdy_o,
        output req_znz_i, req_znz_vld_i,
        input  req_znz_rdy_o,
        input  req_data_o, req_data_vld_o, req_data_last_o,
        output req_data_rdy_i,
        input  dec_num_words_o, dec_num_words_vld_o,
        output dec_num_words_rdy_i,
        input  dec_bpc_o, dec_bpc_vld_o,
        output dec_bpc_rdy_i,
        input  dec_znz_o, dec_znz_vld_o,
        output dec_znz_rdy_i,
        output dec_data_i, dec_data_vld_i,
        input  dec_data_rdy_o
    );

endinterface

// File: rtl/ebpc_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after rr_ptr,
// wrapping cyclically.
module ebpc_rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     any
);

    localparam int IDX_W = $clog2(N_REQ);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand = '0;
        idx  = '0;
        any  = 1'b0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(rr_ptr) + off) % N_REQ);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ebpc_decoder_arbiter.sv
// Shares one EBPC decoder between N_REQ requesters, one whole block per grant,
// with round-robin arbitration on the num_words streams.
module ebpc_decoder_arbiter
    import ebpc_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int DATA_W        = 8,
    parameter int LOG_MAX_WORDS = ebpc_pkg::LOG_MAX_WORDS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    ebpc_decoder_arbiter_if.slave    bus,
    output logic [$clog2(N_REQ)-1:0] grant_idx_o,
    output logic                     busy_o
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e               state;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         grant_idx;
    logic [LOG_MAX_WORDS-1:0] remaining;

    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_any;
    logic                     nw_hs;
    logic                     data_hs;

    ebpc_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req    (bus.req_num_words_vld_i),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign nw_hs   = (state == LEN) && bus.req_num_words_vld_i[grant_idx] && bus.dec_num_words_rdy_i;
    assign data_hs = (state == RUN) && bus.dec_data_vld_i && bus.req_data_rdy_i[grant_idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_idx <= pick_idx;
                        rr_ptr    <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                        state     <= LEN;
                    end
                end
                LEN: begin
                    if (nw_hs) begin
                        remaining <= bus.req_num_words_i[grant_idx];
                        // An empty block produces no output, so release at once.
                        state     <= (bus.req_num_words_i[grant_idx] == '0) ? IDLE : RUN;
                    end
                end
                RUN: begin
                    if (data_hs) begin
                        remaining <= remaining - LOG_MAX_WORDS'(1);
                        if (remaining == LOG_MAX_WORDS'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stream routing is purely combinational; non-owners always see zeros.
    always_comb begin
        bus.req_num_words_rdy_o = '0;
        bus.req_bpc_rdy_o       = '0;
        bus.req_znz_rdy_o       = '0;
        bus.req_data_o          = '0;
        bus.req_data_vld_o      = '0;
        bus.req_data_last_o     = '0;
        bus.dec_num_words_o     = '0;
        bus.dec_num_words_vld_o = 1'b0;
        bus.dec_bpc_o           = '0;
        bus.dec_bpc_vld_o       = 1'b0;
        bus.dec_znz_o           = '0;
        bus.dec_znz_vld_o       = 1'b0;
        bus.dec_data_rdy_o      = 1'b0;

        if (state == LEN) begin
            bus.dec_num_words_o                = bus.req_num_words_i[grant_idx];
            bus.dec_num_words_vld_o            = bus.req_num_words_vld_i[grant_idx];
            bus.req_num_words_rdy_o[grant_idx] = bus.dec_num_words_rdy_i;
        end

        if (state != IDLE) begin
            bus.dec_bpc_o                = bus.req_bpc_i[grant_idx];
            bus.dec_bpc_vld_o            = bus.req_bpc_vld_i[grant_idx];
            bus.req_bpc_rdy_o[grant_idx] = bus.dec_bpc_rdy_i;
            bus.dec_znz_o                = bus.req_znz_i[grant_idx];
            bus.dec_znz_vld_o            = bus.req_znz_vld_i[grant_idx];
            bus.req_znz_rdy_o[grant_idx] = bus.dec_znz_rdy_i;
        end

        if (state == RUN) begin
            bus.req_data_o[grant_idx]      = bus.dec_data_i;
            bus.req_data_vld_o[grant_idx]  = bus.dec_data_vld_i;
            bus.req_data_last_o[grant_idx] = (remaining == LOG_MAX_WORDS'(1));
            bus.dec_data_rdy_o             = bus.req_data_rdy_i[grant_idx];
        end
    end

    assign grant_idx_o = grant_idx;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_ebpc_decoder_arbiter.sv
// Directed bench for ebpc_decoder_arbiter: the bench plays both requesters
// and the decoder, with hand-computed routing expectations.
module tb_ebpc_decoder_arbiter;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 8;
    localparam int LMW    = ebpc_pkg::LOG_MAX_WORDS;

    logic clk;
    logic rst;
    logic grant_idx;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;

    ebpc_decoder_arbiter_if #(
        .N_REQ         (N_REQ),
        .DATA_W        (DATA_W),
        .LOG_MAX_WORDS (LMW)
    ) bus ();

    ebpc_decoder_arbiter #(
        .N_REQ         (N_REQ),
        .DATA_W        (DATA_W),
        .LOG_MAX_WORDS (LMW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus.slave),
        .grant_idx_o (grant_idx),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " busy"},       32'(busy), 32'd0);
        chk({tag, " grant"},      32'(grant_idx), 32'd0);
        chk({tag, " nw_rdy"},     32'(bus.req_num_words_rdy_o), 32'd0);
        chk({tag, " bpc_rdy"},    32'(bus.req_bpc_rdy_o), 32'd0);
        chk({tag, " znz_rdy"},    32'(bus.req_znz_rdy_o), 32'd0);
        chk({tag, " data_vld"},   32'(bus.req_data_vld_o), 32'd0);
        chk({tag, " data_last"},  32'(bus.req_data_last_o), 32'd0);
        chk({tag, " data"},       32'(bus.req_data_o), 32'd0);
        chk({tag, " dec_nw_vld"}, 32'(bus.dec_num_words_vld_o), 32'd0);
        chk({tag, " dec_bpc_vld"}, 32'(bus.dec_bpc_vld_o), 32'd0);
        chk({tag, " dec_znz_vld"}, 32'(bus.dec_znz_vld_o), 32'd0);
        chk({tag, " dec_data_rdy"}, 32'(bus.dec_data_rdy_o), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_idle_outputs("reset");
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Entered in IDLE with requester `who` presenting num_words = n.
    task automatic serve(input int who, input int n, input logic [7:0] base,
                         input bit keep, input bit stall);
        logic [1:0] one_hot;
        one_hot = 2'(1 << who);
        #1;
        chk("pre busy", 32'(busy), 32'd0);
        chk("pre dec_nw_vld", 32'(bus.dec_num_words_vld_o), 32'd0);
        tick();
        // LEN: num_words path and BPC/ZNZ paths open for the owner only
        bus.req_bpc_i     = {8'h3C, 8'hA5};
        bus.req_znz_i     = {8'h69, 8'h96};
        bus.req_bpc_vld_i = 2'b11;
        bus.req_znz_vld_i = 2'b11;
        #1;
        chk("len busy", 32'(busy), 32'd1);
        chk("len grant", 32'(grant_idx), 32'(who));
        chk("len dec_nw_vld", 32'(bus.dec_num_words_vld_o), 32'd1);
        chk("len dec_nw", 32'(bus.dec_num_words_o), 32'(n));
        chk("len nw_rdy", 32'(bus.req_num_words_rdy_o), 32'(one_hot));
        chk("len dec_bpc", 32'(bus.dec_bpc_o), (who == 0) ? 32'hA5 : 32'h3C);
        chk("len dec_znz", 32'(bus.dec_znz_o), (who == 0) ? 32'h96 : 32'h69);
        chk("len bpc_rdy", 32'(bus.req_bpc_rdy_o), 32'(one_hot));
        chk("len znz_rdy", 32'(bus.req_znz_rdy_o), 32'(one_hot));
        chk("len dec_data_rdy", 32'(bus.dec_data_rdy_o), 32'd0);
        tick();
        if (!keep) bus.req_num_words_vld_i[who] = 1'b0;
        bus.req_bpc_vld_i = 2'b00;
        bus.req_znz_vld_i = 2'b00;
        #1;
        chk("post dec_nw_vld", 32'(bus.dec_num_words_vld_o), 32'd0);
        for (int b = 0; b < n; b++) begin
            if (stall && b == 1) begin
                bus.dec_data_i     = 8'hEE;
                bus.dec_data_vld_i = 1'b1;
                bus.req_data_rdy_i = 2'b00;
                #1;
                chk("stall dec_data_rdy", 32'(bus.dec_data_rdy_o), 32'd0);
                tick();
            end
            bus.dec_data_i     = base + 8'(b);
            bus.dec_data_vld_i = 1'b1;
            bus.req_data_rdy_i = 2'b11;
            #1;
            chk("beat data", 32'(bus.req_data_o[who]), 32'(base + 8'(b)));
            chk("beat vld", 32'(bus.req_data_vld_o), 32'(one_hot));
            chk("beat last", 32'(bus.req_data_last_o), (b == n - 1) ? 32'(one_hot) : 32'd0);
            chk("beat dec_data_rdy", 32'(bus.dec_data_rdy_o), 32'd1);
            tick();
        end
        // Surplus decoder output must be held off in IDLE
        bus.dec_data_vld_i = 1'b1;
        #1;
        chk("end busy", 32'(busy), 32'd0);
        chk("end dec_data_rdy", 32'(bus.dec_data_rdy_o), 32'd0);
        chk("end data_vld", 32'(bus.req_data_vld_o), 32'd0);
        bus.dec_data_vld_i = 1'b0;
    endtask

    initial begin
        rst                     = 1'b1;
        bus.req_num_words_i     = '0;
        bus.req_num_words_vld_i = '0;
        bus.req_bpc_i           = '0;
        bus.req_bpc_vld_i       = '0;
        bus.req_znz_i           = '0;
        bus.req_znz_vld_i       = '0;
        bus.req_data_rdy_i      = '0;
        bus.dec_num_words_rdy_i = 1'b1;
        bus.dec_bpc_rdy_i       = 1'b1;
        bus.dec_znz_rdy_i       = 1'b1;
        bus.dec_data_i          = '0;
        bus.dec_data_vld_i      = 1'b0;
        tick();
        do_reset();

        // Single requester 0, five words, with one output stall
        bus.req_num_words_i[0]     = LMW'(5);
        bus.req_num_words_vld_i[0] = 1'b1;
        serve(0, 5, 8'h10, 1'b0, 1'b1);

        // Simultaneous requests after reset: 0, then 1, then 0 again (held vld)
        do_reset();
        bus.req_num_words_i[0]  = LMW'(2);
        bus.req_num_words_i[1]  = LMW'(3);
        bus.req_num_words_vld_i = 2'b11;
        serve(0, 2, 8'h20, 1'b1, 1'b0);
        serve(1, 3, 8'h30, 1'b0, 1'b0);
        serve(0, 2, 8'h40, 1'b0, 1'b0);

        // Empty block from requester 1, then pointer wraps back to 0
        do_reset();
        bus.req_num_words_i[1]     = LMW'(0);
        bus.req_num_words_vld_i[1] = 1'b1;
        serve(1, 0, 8'h00, 1'b0, 1'b0);
        bus.req_num_words_i[0]  = LMW'(1);
        bus.req_num_words_i[1]  = LMW'(1);
        bus.req_num_words_vld_i = 2'b11;
        serve(0, 1, 8'h50, 1'b0, 1'b0);
        serve(1, 1, 8'h60, 1'b0, 1'b0);

        // Reset mid-RUN at beat 3 of 8
        do_reset();
        bus.req_num_words_i[0]     = LMW'(8);
        bus.req_num_words_vld_i[0] = 1'b1;
        tick();
        tick();
        bus.req_num_words_vld_i[0] = 1'b0;
        bus.req_data_rdy_i         = 2'b11;
        for (int b = 0; b < 3; b++) begin
            bus.dec_data_i     = 8'h70 + 8'(b);
            bus.dec_data_vld_i = 1'b1;
            tick();
        end
        bus.dec_data_i = 8'h73;
        #1;
        chk("mid vld", 32'(bus.req_data_vld_o), 32'd1);
        chk("mid data", 32'(bus.req_data_o[0]), 32'h73);
        rst = 1'b1;
        #1;
        check_idle_outputs("mid reset");
        bus.dec_data_vld_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        bus.req_num_words_i[0]     = LMW'(4);
        bus.req_num_words_vld_i[0] = 1'b1;
        serve(0, 4, 8'h80, 1'b0, 1'b0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
